// File: rtl/bcd_counter_n.sv
// Up/down BCD counter with parallel load, snapshot register, terminal-count and sticky wrap flags.
// All state updates on the rising edge of F_IN; CO is combinational.
module bcd_counter_n #(
    parameter int DIGITS  = 6,
    parameter bit RST_DIR = 1'b1
) (
    input  logic                F_IN,
    input  logic                CLR,
    input  logic                ENA,
    input  logic                UP_DN,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] D,
    input  logic                SNAP,
    output logic [4*DIGITS-1:0] Q,
    output logic [4*DIGITS-1:0] QS,
    output logic                CO,
    output logic                OVF
);

    localparam int W = 4 * DIGITS;

    generate
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("bcd_counter_n: DIGITS must be in 1..8");
        end
    endgenerate

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] qs_q, qs_d;
    logic         dir_q, dir_d;
    logic         ovf_q, ovf_d;

    logic [W-1:0] cnt_up, cnt_dn, load_val;
    logic         all_nine, all_zero;

    // Ripple carry/borrow across digits; the wrap cases coincide with all-9 / all-0.
    always_comb begin : step_calc
        logic       carry;
        logic       borrow;
        logic [3:0] dig;
        logic [3:0] din;
        cnt_up   = '0;
        cnt_dn   = '0;
        load_val = '0;
        all_nine = 1'b1;
        all_zero = 1'b1;
        carry    = 1'b1;
        borrow   = 1'b1;
        dig      = '0;
        din      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig      = cnt_q[4*i +: 4];
            din      = D[4*i +: 4];
            all_nine = all_nine & (dig == 4'd9);
            all_zero = all_zero & (dig == 4'd0);
            if (carry && dig == 4'd9) begin
                cnt_up[4*i +: 4] = 4'd0;
            end else if (carry) begin
                cnt_up[4*i +: 4] = dig + 4'd1;
                carry            = 1'b0;
            end else begin
                cnt_up[4*i +: 4] = dig;
            end
            if (borrow && dig == 4'd0) begin
                cnt_dn[4*i +: 4] = 4'd9;
            end else if (borrow) begin
                cnt_dn[4*i +: 4] = dig - 4'd1;
                borrow           = 1'b0;
            end else begin
                cnt_dn[4*i +: 4] = dig;
            end
            load_val[4*i +: 4] = (din > 4'd9) ? 4'd0 : din;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        dir_d = UP_DN;
        qs_d  = SNAP ? cnt_q : qs_q;
        if (LOAD) begin
            cnt_d = load_val;
            ovf_d = 1'b0;
        end else if (ENA) begin
            // Direction used here is the one registered on the previous edge.
            if (dir_q) begin
                cnt_d = cnt_up;
                if (all_nine) ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_dn;
                if (all_zero) ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge F_IN) begin
        if (CLR) begin
            cnt_q <= '0;
            qs_q  <= '0;
            ovf_q <= 1'b0;
            dir_q <= RST_DIR;
        end else begin
            cnt_q <= cnt_d;
            qs_q  <= qs_d;
            ovf_q <= ovf_d;
            dir_q <= dir_d;
        end
    end

    assign Q   = cnt_q;
    assign QS  = qs_q;
    assign OVF = ovf_q;
    assign CO  = ENA & (dir_q ? all_nine : all_zero);

endmodule

// File: doc/bcd_counter_n.md
BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 Parameter DIGITS, default 6, number of BCD digits; legal range 1..8.
REQ-002 Parameter RST_DIR, default 1, direction register value after reset (1 = up, 0 = down).
REQ-003 F_IN  input  1  sole clock; all state updates on rising edge.
REQ-004 CLR  input  1  reset; synchronous, active-high.
REQ-005 ENA  input  1  count enable; 1 = advance one step per F_IN edge.
REQ-006 UP_DN  input  1  direction request; 1 = up, 0 = down; sampled into direction register every edge when not in CLR.
REQ-007 LOAD  input  1  synchronous parallel load of D.
REQ-008 D  input  4*DIGITS  load value, BCD, digit 0 in bits [3:0].
REQ-009 SNAP  input  1  capture request for snapshot register.
REQ-010 Q  output  4*DIGITS  live count, BCD, digit 0 in bits [3:0].
REQ-011 QS  output  4*DIGITS  snapshot of Q.
REQ-012 CO  output  1  terminal-count flag, combinational.
REQ-013 OVF  output  1  sticky wrap flag, registered.

Function
REQ-014 Priority per edge SHALL be CLR > LOAD > ENA count > hold.
REQ-015 Direction register DIR SHALL load UP_DN each non-CLR edge; counting on an edge SHALL use DIR value before that edge (one-cycle direction latency).
REQ-016 Up step: digit 0 +1; any digit at 9 with incoming carry -> 0 and carries to next digit; carry ripples within the same cycle.
REQ-017 Down step: digit 0 -1; any digit at 0 with incoming borrow -> 9 and borrows to next digit.
REQ-018 Up wrap: all digits 9 + step -> all digits 0, OVF set to 1 on same edge.
REQ-019 Down wrap: all digits 0 - step -> all digits 9, OVF set to 1 on same edge.
REQ-020 OVF SHALL remain 1 until CLR or LOAD; LOAD clears OVF.
REQ-021 LOAD: each digit of D > 9 SHALL be stored as 0; valid digits stored unchanged; no count occurs on a LOAD edge even if ENA=1.
REQ-022 ENA=0 and LOAD=0: Q and OVF hold.
REQ-023 CO = ENA AND (DIR=1 ? all digits 9 : all digits 0); asserts in the cycle before a wrap.
REQ-024 SNAP=1 SHALL copy pre-edge Q into QS on that edge; QS holds otherwise; SNAP coincident with LOAD/count captures the old Q, not the new one.
REQ-025 Q SHALL never hold a digit value > 9 in any reachable state.
REQ-026 Out-of-range DIGITS SHALL fail elaboration.

Reset
REQ-027 CLR=1 on an edge: Q = 0, QS = 0, OVF = 0, DIR = RST_DIR; overrides LOAD, SNAP, ENA.
REQ-028 CLR asserted mid-count SHALL zero Q on that same edge; counting resumes on the first edge with CLR=0 and ENA=1.
REQ-029 No state change SHALL occur other than on F_IN rising edge; power-up value undefined until first CLR edge.

Verification (DIGITS=6, RST_DIR=1)
REQ-030 CLR=1 for 4 edges, then ENA=1, UP_DN=1 for 25 edges -> Q=0x000025, OVF=0, QS=0.
REQ-031 LOAD D=0x999998, then 2 up steps -> Q=0x999999 with CO=1, then Q=0x000000 with OVF=1 and CO=0; OVF still 1 after 10 more steps.
REQ-032 CLR, UP_DN=0 for 1 edge, then ENA=1 for 1 edge -> Q=0x999999, OVF=1; 1 more edge -> 0x999998.
REQ-033 LOAD D=0x12A4F7 -> Q=0x120407, OVF=0; ENA=0 for 20 edges -> Q unchanged.
REQ-034 Q=0x000123 counting up, SNAP=1 for one edge -> QS=0x000123, Q=0x000124; LOAD and ENA both 1 -> Q=D, no increment.
REQ-035 CLR pulsed at Q=0x000080 while ENA=1 and SNAP=1 -> Q=0, QS=0, OVF=0 next edge; then resumes 0x000001.
